bcd_conv8: RTL and testbench
============================

# bcd_conv8

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") sitting directly downstream of the 4x4 shift-add multiplier. It captures the 8-bit product when `init` is asserted, which is normally driven from the multiplier's `done`. It converts the product to three BCD digits over a fixed number of cycles and raises `done`, so the result can be shown in decimal on the output pins or a display.

## Interface
- `IN_W`, default 8: binary input width.
- `DIGITS`, default 3: BCD digits produced. Must satisfy 10^DIGITS > 2^IN_W − 1.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `init` in 1: start request. Sampled only in IDLE or DONE.
- `bin` in IN_W: binary value. Captured on the accepting edge only.
- `bcd` out 4*DIGITS: result. `[3:0]` is units, `[7:4]` is tens, `[11:8]` is hundreds.
- `done` out 1: result valid. High while in DONE.
- `busy` out 1: conversion in progress (ADJ or SHIFT).

## Operation
- Reset values: state is IDLE. `bcd`, `done` and `busy` are 0. The scratch register and counter are 0.
- Scratch register is {digits[4*DIGITS-1:0], bin_sh[IN_W-1:0]}. Counter `cnt` is $clog2(IN_W+1) bits.
- IDLE:
  - `init`=1 → load bin_sh=`bin`, clear digits, set cnt=IN_W, go to ADJ.
- ADJ (one cycle): every digit ≥5 gets +3. Digits ≤4 are unchanged. Go to SHIFT.
- SHIFT (one cycle):
  - Scratch shifts left 1 and cnt decrements.
  - If the post-decrement cnt==0 → copy digits into `bcd` and go to DONE. Otherwise go to ADJ.
- DONE:
  - `done`=1 and `bcd` is held.
  - `init`=1 → reload as in IDLE and go to ADJ. `done` drops on that edge.
  - `init`=0 → stay in DONE indefinitely.
- `init` in ADJ or SHIFT is ignored. No queuing.
- Changes on `bin` after the accepting edge have no effect.
- `bcd` changes only on the final SHIFT edge and is stable at all other times, including during a subsequent conversion.
- Add-3 is 4-bit, with no carry between digits. A digit never exceeds 9 after a SHIFT.
- Asynchronous reset mid-conversion aborts immediately, returns to the reset values, and leaves no partial result on `bcd`.

## Timing
- Accepting edge is E0, where `init`=1 is seen in IDLE or DONE.
- `busy` is high after E0 through E(2·IN_W−1).
- ADJ/SHIFT alternate on E1…E(2·IN_W).
- After E(2·IN_W) (E16 for the defaults): `bcd` is valid, `done`=1 and `busy`=0.
- Latency is 2·IN_W cycles. Throughput is one conversion per 2·IN_W+1 cycles.
- A single-cycle `init` pulse is sufficient. A held `init` in DONE restarts a new conversion every 2·IN_W+1 cycles.
- `done` and `busy` are never both 1.

## Configuration
- `BCD_SEG7_EN` defined: adds outputs `seg` out 7*DIGITS, one active-high 7-segment pattern per digit in gfedcba order.
  - The pattern for digit k is in `seg[7k+6:7k]`.
  - `seg` is decoded combinationally from the registered `bcd`, so it has the same timing as `bcd`.
  - Reset shows "0" on every digit: 7'h3F.
- `BCD_SEG7_EN` not defined: no `seg` port and no decoder logic.

## Structure
- Package `bcd_pkg`:
  - state encoding IDLE/ADJ/SHIFT/DONE;
  - the ADJ threshold constant (5) and the add constant (3);
  - the 7-segment pattern constants for 0–9, with blank (7'h00) for 10–15.
- Sub-module `bcd_to_seg7`: one digit to 7 segments. Instantiated DIGITS times under `BCD_SEG7_EN` only.

## Test plan
- Reset: hold `rst_n`=0 → `bcd`=12'h000, `done`=0, `busy`=0. With `BCD_SEG7_EN`, `seg` is 7'h3F per digit.
- `bin`=8'd225 (15×15), 1-cycle `init` → `done` rises exactly 16 cycles after E0 with `bcd`=12'h225. `bin`=0 → 12'h000. `bin`=255 → 12'h255.
- `init` pulsed again at E5 during busy, with `bin` changed to 9 → ignored; the result is still 12'h225 at E16.
- `rst_n` dropped at E7 of a conversion → outputs go to reset values at once. A new `init` with `bin`=8'd99 → `bcd`=12'h099 after 16 cycles.
- In DONE with `bcd`=12'h225, `init` held with `bin`=8'd8 → `done` falls on the next edge and `bcd` holds 12'h225. After 16 more cycles, `bcd`=12'h008 and `done`=1.
- `BCD_SEG7_EN`, `bin`=8'd8 → `seg`=units 7'h7F, tens 7'h3F, hundreds 7'h3F.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, the
// double-dabble adjust constants and the 7-segment digit patterns.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADJ   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Active-high segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // 4-bit add-3 with no carry out; digits below the threshold pass through
  function automatic logic [3:0] digit_adjust(input logic [3:0] d);
    logic [3:0] r;
    if (d >= ADJ_THRESH) begin
      r = d + ADJ_ADD;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Single BCD digit to active-high 7-segment pattern (gfedcba); non-decimal
// codes are blanked.
module bcd_to_seg7 (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  import bcd_pkg::*;

  // Pure lookup, no state
  always_comb begin
    seg_o = seg7_encode(digit_i);
  end

endmodule

// File: rtl/bcd_conv8.sv
// Sequential shift-and-add-3 binary-to-BCD converter with registered result.
// Optional 7-segment outputs are enabled by defining BCD_SEG7_EN.
module bcd_conv8 #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic [IN_W-1:0]       bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy
`ifdef BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);
  import bcd_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_e             state_q;
  logic [SCR_W-1:0]   scr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               done_q;
  logic               busy_q;

  logic [SCR_W-1:0]   adj_scr_d;
  logic [SCR_W-1:0]   shl_scr_d;
  logic [CNT_W-1:0]   cnt_dec_d;

  // Datapath candidates for the ADJ and SHIFT steps
  always_comb begin
    adj_scr_d = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      adj_scr_d[IN_W + 4*k +: 4] = digit_adjust(scr_q[IN_W + 4*k +: 4]);
    end
    shl_scr_d = {scr_q[SCR_W-2:0], 1'b0};
    cnt_dec_d = cnt_q - CNT_W'(1);
  end

  // Control FSM; bcd only updates on the final shift so it is stable otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (init) begin
            scr_q   <= {{BCD_W{1'b0}}, bin};
            cnt_q   <= CNT_W'(IN_W);
            state_q <= ST_ADJ;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_ADJ: begin
          scr_q   <= adj_scr_d;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          scr_q <= shl_scr_d;
          cnt_q <= cnt_dec_d;
          if (cnt_dec_d == '0) begin
            bcd_q   <= shl_scr_d[SCR_W-1 -: BCD_W];
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_ADJ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign busy = busy_q;

`ifdef BCD_SEG7_EN
  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    bcd_to_seg7 u_seg (
      .digit_i (bcd_q[4*k +: 4]),
      .seg_o   (seg[7*k +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_bcd_conv8.sv
// Scoreboard bench for bcd_conv8: expected BCD pushed at stimulus time,
// popped when done rises. Covers seg outputs when BCD_SEG7_EN is defined.
module tb_bcd_conv8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        init  = 1'b0;
  logic [7:0]  bin   = 8'd0;
  logic [11:0] bcd;
  logic        done;
  logic        busy;
`ifdef BCD_SEG7_EN
  logic [20:0] seg;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  bcd_conv8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .bin   (bin),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy)
`ifdef BCD_SEG7_EN
    ,
    .seg   (seg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input logic [3:0] d);
    logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h00;
    return t[d];
  endfunction

  // Drive one accepted request; returns at the falling edge after E0
  task automatic start(input logic [7:0] v, input bit hold);
    @(negedge clk);
    bin  = v;
    init = 1'b1;
    sb.push_back(model_bcd(int'(v)));
    @(posedge clk);
    @(negedge clk);
    if (!hold) init = 1'b0;
    check("busy_after_e0", busy, 1);
    check("done_after_e0", done, 0);
  endtask

  // Wait (bounded) for done; elapsed = edges already seen since E0
  task automatic wait_done(input string tag, input int elapsed);
    int n = elapsed;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_lat"}, n, 16);
    if (sb.size() > 0) begin
      check({tag, "_bcd"}, bcd, sb.pop_front());
    end else begin
      check({tag, "_sb_empty"}, 1, 0);
    end
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rv;
    repeat (3) @(negedge clk);
    check("rst_bcd", bcd, 12'h000);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
`ifdef BCD_SEG7_EN
    check("rst_seg", seg, {7'h3F, 7'h3F, 7'h3F});
`endif
    rst_n = 1'b1;

    start(8'd225, 1'b0);
    wait_done("c225", 0);
    start(8'd0, 1'b0);
    wait_done("c0", 0);
    start(8'd255, 1'b0);
    wait_done("c255", 0);

    // Re-init during busy must be ignored, bcd must hold the old result
    start(8'd225, 1'b0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    bin  = 8'd9;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    check("busy_bcd_hold", bcd, model_bcd(255));
    wait_done("ignore_init", 5);

    // Held init from DONE: done falls on next edge, bcd holds
    start(8'd8, 1'b1);
    check("restart_bcd_hold", bcd, model_bcd(225));
    wait_done("hold8", 0);
    sb.push_back(model_bcd(8));
    @(posedge clk);
    @(negedge clk);
    check("rerun_done", done, 0);
    check("rerun_busy", busy, 1);
    check("rerun_bcd_hold", bcd, model_bcd(8));
    init = 1'b0;
    wait_done("rerun8", 0);
`ifdef BCD_SEG7_EN
    check("seg8", seg, {model_seg(4'd0), model_seg(4'd0), model_seg(4'd8)});
`endif

    // Asynchronous reset mid-conversion
    start(8'd50, 1'b0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bcd", bcd, 12'h000);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start(8'd99, 1'b0);
    wait_done("c99", 0);

    for (int i = 0; i < 4; i++) begin
      rv = 8'($urandom_range(0, 255));
      start(rv, 1'b0);
      wait_done("rand", 0);
`ifdef BCD_SEG7_EN
      check("rand_seg", seg, {model_seg(model_bcd(int'(rv)) >> 8),
                              model_seg(4'(model_bcd(int'(rv)) >> 4)),
                              model_seg(4'(model_bcd(int'(rv))))});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
